sha_pipelined_digest_stage: RTL and testbench
=============================================

# sha_pipelined_digest_stage

Tail-end consumer of the super-pipelined SHA core. It takes the round state emerging from the last pipelined round stage, adds the chaining value (feed-forward) word-wise to form the block digest, and buffers results in a small FIFO. The FIFO drains through a ready/valid handshake to downstream logic. Because the round pipeline cannot stall, the block provides an early almost-full throttle for the issuing side and a sticky overflow flag.

## Interface
- DEPTH, 8: FIFO entries; power of two, >= 2.
- SKID, 4: number of beats upstream may still deliver after almost_full_o rises; 0 <= SKID < DEPTH.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- state_i  in  HashState (256: a in [255:224] … h in [31:0])  round state from the final pipeline stage.
- base_i  in  HashState  chaining value travelling alongside state_i.
- valid_i  in  1  state_i/base_i/newblock_i valid this cycle.
- newblock_i  in  1  beat is the first block of a new message; carried as a tag.
- digest_o  out  HashState  head-of-FIFO digest.
- newblock_o  out  1  tag of the head entry.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  downstream accepts the head entry when valid_o && ready_i.
- almost_full_o  out  1  free entries <= SKID.
- overflow_o  out  1  sticky; a beat was dropped.
- count_o  out  32  digests popped since reset; wraps modulo 2^32.

## Operation
- Add stage:
  - On valid_i, register sum[i] = state_i[i] + base_i[i] mod 2^32 for each of the 8 words independently, with no inter-word carry.
  - Register newblock_i and a valid bit alongside the sum.
  - Beats with valid_i = 0 register valid = 0; data is don't-care.
- FIFO:
  - Circular buffer of DEPTH entries, each 257 bits (digest + tag).
  - Read and write pointers are log2(DEPTH)+1 bits; the MSB distinguishes full from empty, and pointers wrap naturally.
  - First-word-fall-through: digest_o/newblock_o always show the head entry.
  - digest_o/newblock_o are don't-care when valid_o = 0, but must not be X after reset.
- Push: occurs when the add-stage valid bit is 1.
  - Not full: write the entry and advance the write pointer.
  - Full with pop in the same cycle: push is accepted and occupancy is unchanged.
  - Full without pop: entry dropped, overflow_o set; pointers and contents unchanged.
- Pop: valid_o && ready_i advances the read pointer and increments count_o.
  - ready_i while empty has no effect.
- Simultaneous push and pop while empty: pop has no effect; the push lands.
- almost_full_o = (DEPTH − occupancy) <= SKID, computed from registered occupancy, so it is combinational from flops only.
- overflow_o clears only on rst.

## Timing
- Reset: all outputs are 0 while rst is high and after it deasserts.
  - digest_o, newblock_o, valid_o, almost_full_o, overflow_o, count_o = 0.
  - Add-stage valid bit and both pointers = 0; FIFO contents need not be cleared.
- Reset mid-operation discards the add stage and all FIFO entries immediately (asynchronous).
- Latency: valid_i at cycle t -> sum registered at edge t+1 -> written into the FIFO at edge t+2.
  - valid_o rises in cycle t+2 when the FIFO was empty.
  - There is no empty-bypass; latency is always 2.
- Throughput: one push and one pop per cycle sustained.
  - Occupancy changes by −1, 0 or +1 per cycle.
- count_o updates on the edge ending the pop cycle.
- almost_full_o and valid_o reflect occupancy after the previous edge.

## Test plan
- Reset/idle: assert rst mid-cycle with 3 entries queued -> all outputs immediately 0; after release, valid_o stays 0 with valid_i = 0.
- Word-wise wrap: state_i words all 0xFFFFFFFF, base_i words all 0x00000002, newblock_i = 1 at cycle t -> cycle t+2: valid_o = 1, every digest_o word = 0x00000001, newblock_o = 1; pop -> count_o = 1.
- Known digest: state_i = SHA-256("abc") final digest minus IV word-wise, base_i = IV 6a09e667…5be0cd19 -> digest_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Fill/throttle (DEPTH = 8, SKID = 4), ready_i = 0, 8 consecutive beats:
  - almost_full_o rises in the cycle occupancy reaches 4.
  - 9th beat -> overflow_o = 1 and stays 1.
  - Drain returns beats 1..8 in order, count_o = 8.
- Full with simultaneous push/pop: FIFO full, ready_i = 1, valid_i = 1 for 20 cycles -> no overflow, occupancy stays 8, output order preserved, count_o = 20.
- Random backpressure: 1000 beats with random valid_i/ready_i, upstream obeying almost_full_o -> overflow_o = 0 and a scoreboard match on all digests and tags.

Source files
------------

// File: rtl/sha_pipelined_digest_stage.sv
// SHA pipeline tail: word-wise feed-forward add, then a first-word-fall-through
// digest FIFO with an early almost-full throttle and a sticky overflow flag.
module sha_pipelined_digest_stage #(
  parameter int DEPTH = 8,
  parameter int SKID  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] state_i,
  input  logic [255:0] base_i,
  input  logic         valid_i,
  input  logic         newblock_i,
  output logic [255:0] digest_o,
  output logic         newblock_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         almost_full_o,
  output logic         overflow_o,
  output logic [31:0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] SKID_W  = (AW+1)'(SKID);

  logic [255:0] sum_d;
  logic [255:0] sum_q;
  logic         nb_q;
  logic         v_q;

  logic [256:0] mem [DEPTH];
  logic [256:0] head;
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  occ;
  logic [AW:0]  free;
  logic         full;
  logic         empty;
  logic         pop;
  logic         push;
  logic         drop;

  // Each 32-bit word is summed on its own; carries never cross word lanes.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 8; i++) begin
      sum_d[i*32 +: 32] = state_i[i*32 +: 32] + base_i[i*32 +: 32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= 1'b0;
      nb_q  <= 1'b0;
      sum_q <= '0;
    end else begin
      v_q   <= valid_i;
      nb_q  <= newblock_i;
      sum_q <= sum_d;
    end
  end

  always_comb begin
    occ   = wr_ptr - rd_ptr;
    free  = DEPTH_W - occ;
    full  = (occ == DEPTH_W);
    empty = (occ == '0);
    pop   = !empty && ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push  = v_q && (!full || pop);
    drop  = v_q && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {nb_q, sum_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        count_o <= count_o + 32'd1;
      end
      if (drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // Storage is never cleared, so the head is masked while the FIFO is empty.
  always_comb begin
    head          = mem[rd_ptr[AW-1:0]];
    valid_o       = !empty;
    digest_o      = valid_o ? head[255:0] : '0;
    newblock_o    = valid_o & head[256];
    almost_full_o = (free <= SKID_W);
  end

endmodule

// File: tb/tb_sha_pipelined_digest_stage.sv
// Directed-vector and sequence bench for sha_pipelined_digest_stage, with a
// queue of expected digests checked in order on every pop.
module tb_sha_pipelined_digest_stage;

  logic         clk;
  logic         rst;
  logic [255:0] state_i;
  logic [255:0] base_i;
  logic         valid_i;
  logic         newblock_i;
  logic [255:0] digest_o;
  logic         newblock_o;
  logic         valid_o;
  logic         ready_i;
  logic         almost_full_o;
  logic         overflow_o;
  logic [31:0]  count_o;

  int errors = 0;
  int checks = 0;
  logic [256:0] q[$];

  sha_pipelined_digest_stage #(.DEPTH(8), .SKID(4)) dut (
    .clk(clk), .rst(rst), .state_i(state_i), .base_i(base_i),
    .valid_i(valid_i), .newblock_i(newblock_i), .digest_o(digest_o),
    .newblock_o(newblock_o), .valid_o(valid_o), .ready_i(ready_i),
    .almost_full_o(almost_full_o), .overflow_o(overflow_o), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] s;
    logic [255:0] b;
    logic         nb;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] wadd(input logic [255:0] s, input logic [255:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = s[i*32 +: 32] + b[i*32 +: 32];
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // One clock: apply ready/valid, check the head against the queue if it pops.
  task automatic tick(input logic v, input logic [255:0] s, input logic [255:0] b,
                      input logic nb, input logic r, input string name);
    logic [256:0] e;
    ready_i = r;
    if (r && valid_o) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: pop with nothing expected, got %h", name, digest_o);
      end else begin
        e = q.pop_front();
        chk({name, " digest"}, digest_o, e[255:0]);
        chk({name, " tag"}, {255'd0, newblock_o}, {255'd0, e[256]});
      end
    end
    valid_i    = v;
    state_i    = s;
    base_i     = b;
    newblock_i = nb;
    if (v) q.push_back({nb, wadd(s, b)});
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    valid_i = 1'b0;
    ready_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic chk_zero(input string name);
    chk({name, " valid_o"}, {255'd0, valid_o}, 256'd0);
    chk({name, " digest_o"}, digest_o, 256'd0);
    chk({name, " newblock_o"}, {255'd0, newblock_o}, 256'd0);
    chk({name, " almost_full_o"}, {255'd0, almost_full_o}, 256'd0);
    chk({name, " overflow_o"}, {255'd0, overflow_o}, 256'd0);
    chk({name, " count_o"}, {224'd0, count_o}, 256'd0);
  endtask

  initial begin
    logic [255:0] iv;
    logic [255:0] abc;
    logic [255:0] seq_s;
    logic [255:0] seq_b;
    int sent;
    int n;

    rst = 1'b0;
    state_i = '0; base_i = '0; valid_i = 1'b0; newblock_i = 1'b0; ready_i = 1'b0;

    iv  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    abc = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    seq_s = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
    seq_b = {8{32'hffffffff}};

    vecs[0].s = {8{32'hffffffff}}; vecs[0].b = {8{32'h00000002}};
    vecs[0].nb = 1'b1;             vecs[0].exp = {8{32'h00000001}};
    for (int i = 0; i < 8; i++) vecs[1].s[i*32 +: 32] = abc[i*32 +: 32] - iv[i*32 +: 32];
    vecs[1].b = iv; vecs[1].nb = 1'b0; vecs[1].exp = abc;
    vecs[2].s = {8{32'h80000000}}; vecs[2].b = {8{32'h80000000}};
    vecs[2].nb = 1'b0;             vecs[2].exp = '0;
    vecs[3].s = {8{32'h12345678}}; vecs[3].b = {8{32'h11111111}};
    vecs[3].nb = 1'b1;             vecs[3].exp = {8{32'h23456789}};
    vecs[4].s = seq_s; vecs[4].b = seq_b; vecs[4].nb = 1'b1;
    vecs[4].exp = 256'h00000000_00000001_00000002_00000003_00000004_00000005_00000006_00000007;

    // Power-on reset, checked while held and after release.
    #1 rst = 1'b1;
    #2 chk_zero("reset held");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1 chk_zero("reset released");
    @(posedge clk); #1;

    // Table: single beat, latency 2, then pop.
    for (int k = 0; k < 5; k++) begin
      ready_i = 1'b0;
      valid_i = 1'b1; state_i = vecs[k].s; base_i = vecs[k].b; newblock_i = vecs[k].nb;
      @(posedge clk); #1;
      valid_i = 1'b0;
      chk($sformatf("vec%0d valid_o at t+1", k), {255'd0, valid_o}, 256'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d valid_o at t+2", k), {255'd0, valid_o}, 256'd1);
      chk($sformatf("vec%0d digest_o", k), digest_o, vecs[k].exp);
      chk($sformatf("vec%0d newblock_o", k), {255'd0, newblock_o}, {255'd0, vecs[k].nb});
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      chk($sformatf("vec%0d count_o", k), {224'd0, count_o}, 256'(k + 1));
      chk($sformatf("vec%0d valid_o after pop", k), {255'd0, valid_o}, 256'd0);
    end

    // Asynchronous reset with three entries queued.
    for (int j = 1; j <= 3; j++) tick(1'b1, {8{32'(j)}}, '0, 1'b1, 1'b0, "rq");
    tick(1'b0, '0, '0, 1'b0, 1'b0, "rq");
    tick(1'b0, '0, '0, 1'b0, 1'b0, "rq");
    chk("rq valid_o before reset", {255'd0, valid_o}, 256'd1);
    #2 rst = 1'b1;
    #1 chk_zero("mid-cycle reset");
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    for (int j = 0; j < 3; j++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b0, "idle");
      chk("idle valid_o after reset", {255'd0, valid_o}, 256'd0);
    end

    // Fill with no drain: throttle at occupancy 4, ninth beat overflows.
    apply_reset();
    for (int j = 1; j <= 9; j++) begin
      tick(1'b1, {8{32'(j)}}, '0, 1'(j % 2), 1'b0, "fill");
      chk($sformatf("fill almost_full_o occ=%0d", j - 1), {255'd0, almost_full_o},
          {255'd0, 1'(j - 1 >= 4)});
    end
    void'(q.pop_back());
    chk("fill overflow_o before drop", {255'd0, overflow_o}, 256'd0);
    tick(1'b0, '0, '0, 1'b0, 1'b0, "fill");
    chk("fill overflow_o after drop", {255'd0, overflow_o}, 256'd1);
    repeat (3) tick(1'b0, '0, '0, 1'b0, 1'b0, "fill");
    chk("fill overflow_o sticky", {255'd0, overflow_o}, 256'd1);
    for (int j = 0; j < 8; j++) tick(1'b0, '0, '0, 1'b0, 1'b1, "drain");
    chk("drain count_o", {224'd0, count_o}, 256'd8);
    chk("drain valid_o", {255'd0, valid_o}, 256'd0);
    chk("drain overflow_o sticky", {255'd0, overflow_o}, 256'd1);
    chk("drain almost_full_o", {255'd0, almost_full_o}, 256'd0);

    // Full FIFO with simultaneous push and pop for 20 cycles.
    apply_reset();
    for (int j = 1; j <= 8; j++) tick(1'b1, {8{32'(j)}}, '0, 1'(j % 3 == 0), 1'b0, "full");
    tick(1'b0, '0, '0, 1'b0, 1'b0, "full");
    tick(1'b0, '0, '0, 1'b0, 1'b0, "full");
    tick(1'b1, {8{32'd9}}, '0, 1'b0, 1'b0, "full");
    for (int j = 10; j <= 29; j++) begin
      if (j <= 28) tick(1'b1, {8{32'(j)}}, '0, 1'(j % 3 == 0), 1'b1, "fullpp");
      else tick(1'b0, '0, '0, 1'b0, 1'b1, "fullpp");
      chk("fullpp almost_full_o", {255'd0, almost_full_o}, 256'd1);
      chk("fullpp overflow_o", {255'd0, overflow_o}, 256'd0);
    end
    chk("fullpp count_o", {224'd0, count_o}, 256'd20);
    for (int j = 0; j < 8; j++) tick(1'b0, '0, '0, 1'b0, 1'b1, "fulldrain");
    chk("fulldrain valid_o", {255'd0, valid_o}, 256'd0);
    chk("fulldrain count_o", {224'd0, count_o}, 256'd28);

    // Random traffic, upstream honouring almost_full_o.
    apply_reset();
    sent = 0;
    n = 0;
    while (sent < 1000 && n < 20000) begin
      logic v;
      v = !almost_full_o && ($urandom_range(0, 9) < 7);
      tick(v, rnd256(), rnd256(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
      if (v) sent++;
      n++;
    end
    n = 0;
    while (q.size() != 0 && n < 200) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1, "rand");
      n++;
    end
    chk("rand beats sent", 256'(sent), 256'd1000);
    chk("rand expected left", 256'(q.size()), 256'd0);
    chk("rand overflow_o", {255'd0, overflow_o}, 256'd0);
    chk("rand count_o", {224'd0, count_o}, 256'd1000);
    chk("rand valid_o", {255'd0, valid_o}, 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
